// File: rtl/pipe_muldiv_pkg.sv
// Shared op encodings and helpers for the EX-stage multiply/divide unit.
package pipe_muldiv_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
  } mul_opnd_t;

  // Magnitude of a 32-bit value; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/pipe_divider.sv
// Iterative restoring divider: 32 shift/subtract cycles on magnitudes, sign
// fixup applied combinationally while done is high (33rd cycle after start).
module pipe_divider
  import pipe_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem, quo, dvs;
  logic [5:0]  cnt;
  logic        active, neg_q, neg_r;
  logic [32:0] shifted;
  logic [31:0] sub;
  logic        ge;

  assign shifted = {rem, quo[31]};
  assign ge      = (shifted >= {1'b0, dvs});
  // Only used when ge holds, so the true difference fits in 32 bits.
  assign sub     = shifted[31:0] - dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem    <= '0;
      quo    <= mag32(dividend, is_signed);
      dvs    <= mag32(divisor, is_signed);
      neg_q  <= is_signed & (dividend[31] ^ divisor[31]);
      neg_r  <= is_signed & dividend[31];
    end else if (active) begin
      if (cnt != 6'd32) begin
        cnt <= cnt + 6'd1;
        rem <= ge ? sub : shifted[31:0];
        quo <= {quo[30:0], ge};
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done      = active && (cnt == 6'd32);
  assign quotient  = neg_q ? (~quo + 32'd1) : quo;
  assign remainder = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/pipe_muldiv.sv
// EX-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning architectural HI/LO.
// Divider present only when PIPE_MULDIV_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module pipe_muldiv
  import pipe_muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  mul_opnd_t  opnd, opnd_n;
  logic [31:0] hi_n, lo_n;
  logic       done_n;
  logic [63:0] prod;

  // Extending by sgn makes one 64-bit multiplier serve both MULT and MULTU.
  assign prod = {{32{opnd.sgn & opnd.a[31]}}, opnd.a} *
                {{32{opnd.sgn & opnd.b[31]}}, opnd.b};
  assign busy = (state != S_IDLE);

`ifdef PIPE_MULDIV_DIV_EN
  logic        div_start, div_sgn, div_done, dz, dz_n;
  logic [31:0] div_q, div_r;

  assign div_sgn = (md_op == MD_DIV);

  pipe_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_sgn),
    .dividend  (src_a),
    .divisor   (src_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    opnd_n  = opnd;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
`ifdef PIPE_MULDIV_DIV_EN
    dz_n      = dz;
    div_start = 1'b0;
`endif
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_valid) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                state_n = S_MUL;
                cnt_n   = CW'(MUL_LAT - 1);
                opnd_n  = '{a: src_a, b: src_b, sgn: (md_op == MD_MULT)};
              end
`ifdef PIPE_MULDIV_DIV_EN
              MD_DIV, MD_DIVU: begin
                state_n   = S_DIV;
                dz_n      = (src_b == 32'd0);
                div_start = (src_b != 32'd0);
              end
`endif
              MD_MTHI: hi_n = src_a;
              MD_MTLO: lo_n = src_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            hi_n    = prod[63:32];
            lo_n    = prod[31:0];
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
`ifdef PIPE_MULDIV_DIV_EN
        S_DIV: begin
          // Divide by zero finishes after one busy cycle and leaves HI/LO alone.
          if (dz) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else if (div_done) begin
            hi_n    = div_r;
            lo_n    = div_q;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
`endif
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      opnd  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
`ifdef PIPE_MULDIV_DIV_EN
      dz    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      opnd  <= opnd_n;
      hi    <= hi_n;
      lo    <= lo_n;
      done  <= done_n;
`ifdef PIPE_MULDIV_DIV_EN
      dz    <= dz_n;
`endif
    end
  end

endmodule
